reg_to_axi_mgr: RTL

Protocol converter from the register interface to AXI4: a regbus subordinate port whose requests are reissued as single-beat AXI4 manager transactions. It is the counterpart of the AXI-to-regbus path and lets regbus-side initiators (debug, config sequencers) reach AXI-mapped memory and peripherals. One transaction is outstanding at a time. AxiDataWidth >= RegDataWidth.

---
 rtl/reg_to_axi_mgr_pkg.sv | 128 ++++++++++++
 rtl/reg_to_axi_mgr.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_to_axi_mgr_pkg.sv
// Shared definitions for the regbus-to-AXI4 manager bridge: FSM states,
// AXI response encodings, helpers and default bus struct types.
package reg_to_axi_mgr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WAIT_B,
      READ,
      WAIT_R,
      RESP
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   // Only subordinate and decode errors are reported to the regbus side.
   function automatic logic resp_is_error(input logic [1:0] resp);
      logic err;
      case (resp)
         RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
         RESP_SLVERR, RESP_DECERR: err = 1'b1;
         default:                  err = 1'b0;
      endcase
      return err;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

   // Default bus widths, used when the bridge is elaborated stand-alone.
   localparam int unsigned DEF_ADDR_W     = 32;
   localparam int unsigned DEF_AXI_DATA_W = 64;
   localparam int unsigned DEF_REG_DATA_W = 32;
   localparam int unsigned DEF_ID_W       = 4;
   localparam int unsigned DEF_USER_W     = 1;

   typedef struct packed {
      logic [DEF_ID_W-1:0]   id;
      logic [DEF_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
      logic                  lock;
      logic [3:0]            cache;
      logic [2:0]            prot;
      logic [3:0]            qos;
      logic [3:0]            region;
      logic [5:0]            atop;
      logic [DEF_USER_W-1:0] user;
   } axi_def_aw_t;

   typedef struct packed {
      logic [DEF_ID_W-1:0]   id;
      logic [DEF_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
      logic                  lock;
      logic [3:0]            cache;
      logic [2:0]            prot;
      logic [3:0]            qos;
      logic [3:0]            region;
      logic [DEF_USER_W-1:0] user;
   } axi_def_ar_t;

   typedef struct packed {
      logic [DEF_AXI_DATA_W-1:0]   data;
      logic [DEF_AXI_DATA_W/8-1:0] strb;
      logic                        last;
      logic [DEF_USER_W-1:0]       user;
   } axi_def_w_t;

   typedef struct packed {
      logic [DEF_ID_W-1:0]   id;
      logic [1:0]            resp;
      logic [DEF_USER_W-1:0] user;
   } axi_def_b_t;

   typedef struct packed {
      logic [DEF_ID_W-1:0]       id;
      logic [DEF_AXI_DATA_W-1:0] data;
      logic [1:0]                resp;
      logic                      last;
      logic [DEF_USER_W-1:0]     user;
   } axi_def_r_t;

   typedef struct packed {
      axi_def_aw_t aw;
      logic        aw_valid;
      axi_def_w_t  w;
      logic        w_valid;
      logic        b_ready;
      axi_def_ar_t ar;
      logic        ar_valid;
      logic        r_ready;
   } axi_def_req_t;

   typedef struct packed {
      logic       aw_ready;
      logic       ar_ready;
      logic       w_ready;
      logic       b_valid;
      axi_def_b_t b;
      logic       r_valid;
      axi_def_r_t r;
   } axi_def_rsp_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0]       addr;
      logic                        write;
      logic [DEF_REG_DATA_W-1:0]   wdata;
      logic [DEF_REG_DATA_W/8-1:0] wstrb;
      logic                        valid;
   } reg_def_req_t;

   typedef struct packed {
      logic [DEF_REG_DATA_W-1:0] rdata;
      logic                      error;
      logic                      ready;
   } reg_def_rsp_t;

endpackage

// File: rtl/reg_to_axi_mgr.sv
// Regbus subordinate that reissues each request as one single-beat AXI4
// manager transaction. One transaction in flight; all outputs are decoded
// from registered state so nothing on axi_rsp_i reaches reg_rsp_o directly.
module reg_to_axi_mgr
   import reg_to_axi_mgr_pkg::*;
#(
   parameter int unsigned           AxiAddrWidth = DEF_ADDR_W,
   parameter int unsigned           AxiDataWidth = DEF_AXI_DATA_W,
   parameter int unsigned           AxiIdWidth   = DEF_ID_W,
   parameter int unsigned           AxiUserWidth = DEF_USER_W,
   parameter int unsigned           RegDataWidth = DEF_REG_DATA_W,
   parameter logic [AxiIdWidth-1:0] AxiId        = '0,
   parameter type                   axi_req_t    = axi_def_req_t,
   parameter type                   axi_rsp_t    = axi_def_rsp_t,
   parameter type                   reg_req_t    = reg_def_req_t,
   parameter type                   reg_rsp_t    = reg_def_rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  reg_req_t reg_req_i,
   output reg_rsp_t reg_rsp_o,
   output axi_req_t axi_req_o,
   input  axi_rsp_t axi_rsp_i,
   output logic     busy_o
);

   localparam int unsigned RegStrbWidth = RegDataWidth / 8;
   localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;
   localparam int unsigned NumLanes     = AxiDataWidth / RegDataWidth;
   localparam int unsigned LaneLsb      = $clog2(RegStrbWidth);
   localparam int unsigned LaneBits     = (NumLanes > 1) ? $clog2(NumLanes) : 1;
   localparam logic [2:0]  AxSize       = 3'($clog2(RegStrbWidth));

   // Parameter sanity, caught at elaboration.
   if (!is_pow2(RegDataWidth) || RegDataWidth < 8) begin : gen_err_reg_width
      $error("RegDataWidth must be a power of two and at least 8");
   end
   if (!is_pow2(AxiDataWidth) || (AxiDataWidth % RegDataWidth) != 0) begin : gen_err_axi_width
      $error("AxiDataWidth must be a power of two and a multiple of RegDataWidth");
   end
   if ($bits(axi_req_o.aw.addr) != AxiAddrWidth || $bits(axi_req_o.aw.user) != AxiUserWidth) begin : gen_err_types
      $error("axi_req_t field widths do not match AxiAddrWidth/AxiUserWidth");
   end

   state_e                  state_q, state_d;
   logic [AxiAddrWidth-1:0] addr_q, addr_d;
   logic [RegDataWidth-1:0] wdata_q, wdata_d;
   logic [RegStrbWidth-1:0] wstrb_q, wstrb_d;
   logic [RegDataWidth-1:0] rdata_q, rdata_d;
   logic                    error_q, error_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [LaneBits-1:0]     lane;

   // Which regbus-wide lane of the AXI data bus the latched address selects.
   if (NumLanes > 1) begin : gen_lane
      assign lane = addr_q[LaneLsb +: LaneBits];
   end else begin : gen_single_lane
      assign lane = '0;
   end

   // State and request/response latches.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         error_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         error_q   <= error_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Next-state logic: request capture, per-channel handshake tracking, response capture.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      error_d   = error_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: begin
            if (reg_req_i.valid) begin
               addr_d    = reg_req_i.addr;
               wdata_d   = reg_req_i.wdata;
               wstrb_d   = reg_req_i.wstrb;
               rdata_d   = '0;
               error_d   = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (!reg_req_i.write) begin
                  state_d = READ;
               end else if (reg_req_i.wstrb == '0) begin
                  // Nothing to write: acknowledge without touching AXI.
                  state_d = RESP;
               end else begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (axi_rsp_i.aw_ready) aw_done_d = 1'b1;
            if (axi_rsp_i.w_ready)  w_done_d  = 1'b1;
            if (aw_done_d && w_done_d) state_d = WAIT_B;
         end
         WAIT_B: begin
            if (axi_rsp_i.b_valid) begin
               error_d = resp_is_error(axi_rsp_i.b.resp);
               state_d = RESP;
            end
         end
         READ: begin
            if (axi_rsp_i.ar_ready) state_d = WAIT_R;
         end
         WAIT_R: begin
            if (axi_rsp_i.r_valid) begin
               // Data is forwarded even when the response is an error.
               rdata_d = RegDataWidth'(axi_rsp_i.r.data >> (lane * RegDataWidth));
               error_d = resp_is_error(axi_rsp_i.r.resp);
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Bus outputs decoded from registered state only.
   always_comb begin
      axi_req_o           = '0;
      axi_req_o.aw.id     = AxiId;
      axi_req_o.aw.addr   = addr_q;
      axi_req_o.aw.len    = 8'd0;
      axi_req_o.aw.size   = AxSize;
      axi_req_o.aw.burst  = BURST_INCR;
      axi_req_o.aw_valid  = (state_q == WRITE) && !aw_done_q;
      axi_req_o.w.data    = AxiDataWidth'(wdata_q) << (lane * RegDataWidth);
      axi_req_o.w.strb    = AxiStrbWidth'(wstrb_q) << (lane * RegStrbWidth);
      axi_req_o.w.last    = 1'b1;
      axi_req_o.w_valid   = (state_q == WRITE) && !w_done_q;
      axi_req_o.b_ready   = (state_q == WAIT_B);
      axi_req_o.ar.id     = AxiId;
      axi_req_o.ar.addr   = addr_q;
      axi_req_o.ar.len    = 8'd0;
      axi_req_o.ar.size   = AxSize;
      axi_req_o.ar.burst  = BURST_INCR;
      axi_req_o.ar_valid  = (state_q == READ);
      axi_req_o.r_ready   = (state_q == WAIT_R);

      reg_rsp_o           = '0;
      reg_rsp_o.ready     = (state_q == RESP);
      reg_rsp_o.rdata     = rdata_q;
      reg_rsp_o.error     = error_q;
   end

   assign busy_o = (state_q != IDLE);

   // Response IDs, user bits and the like are intentionally ignored.
   logic unused_inputs;
   assign unused_inputs = ^{axi_rsp_i, reg_req_i};

endmodule
